// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data-cache controller.
package dcache_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned INDEX_W_DEF = 6;
    localparam int unsigned TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        FLUSH
    } dcache_state_e;

    // Line index of a byte address (word offset bits dropped); caller truncates to index width.
    function automatic logic [63:0] index_of(input logic [63:0] byte_addr, input int unsigned index_w);
        return (byte_addr >> 2) & ((64'd1 << index_w) - 64'd1);
    endfunction

    // Tag of a byte address; caller truncates to tag width.
    function automatic logic [63:0] tag_of(input logic [63:0] byte_addr, input int unsigned index_w);
        return byte_addr >> (index_w + 2);
    endfunction

endpackage

// File: rtl/dcache_perf_cnt.sv
// Hit/miss saturating event counters for the data cache (built only with DCACHE_PERF_EN).
`ifdef DCACHE_PERF_EN
module dcache_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        hit_inc,
    input  logic        miss_inc,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    // Counters hold at all-ones instead of wrapping; clr restarts the measurement window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_inc && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data-cache controller, one word per line.
// Optional feature: define DCACHE_PERF_EN to add hit_cnt/miss_cnt performance counter ports.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int INDEXWIDTH = 6,
    localparam int TAG_W      = ADDR_W - INDEXWIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  flush,
    output logic                  flush_busy,
    input  logic                  valid_data,
    output logic                  cs_valid,
    output logic                  web_valid,
    output logic                  oe_valid,
    output logic [INDEXWIDTH-1:0] addr_index,
    input  logic [TAG_W-1:0]      tag_rdata,
    output logic                  tag_we,
    output logic [TAG_W-1:0]      tag_wdata,
    input  logic [DATA_W-1:0]     data_rdata,
    output logic                  data_we,
    output logic [DATA_W-1:0]     data_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
`ifdef DCACHE_PERF_EN
   ,output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    dcache_state_e         state;
    logic [ADDR_W-1:0]     lat_addr;
    logic                  lat_we;
    logic [DATA_W-1:0]     lat_wdata;
    logic [INDEXWIDTH-1:0] flush_cnt;
    logic                  flush_pend;

    logic [INDEXWIDTH-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic                  flush_start;

    assign req_index   = INDEXWIDTH'(index_of(64'(lat_addr), INDEXWIDTH));
    assign req_tag     = TAG_W'(tag_of(64'(lat_addr), INDEXWIDTH));
    assign hit         = valid_data && (tag_rdata == req_tag);
    assign flush_start = (state == IDLE) && (flush || flush_pend);

    // Sequencer: request latching, state transitions, flush counter and registered memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            flush_cnt  <= '0;
            flush_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // A flush arriving mid-request is remembered so a single-cycle pulse is not lost.
            if (flush && (state != IDLE) && (state != FLUSH))
                flush_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (flush_start) begin
                        state      <= FLUSH;
                        flush_cnt  <= '0;
                        flush_pend <= 1'b0;
                    end else if (core_req) begin
                        state     <= LOOKUP;
                        lat_addr  <= core_addr;
                        lat_we    <= core_we;
                        lat_wdata <= core_wdata;
                    end
                end
                LOOKUP: begin
                    if (lat_we) begin
                        state     <= MEM_WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {lat_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= lat_wdata;
                    end else if (hit) begin
                        state <= IDLE;
                    end else begin
                        state    <= MEM_RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {lat_addr[ADDR_W-1:2], 2'b00};
                    end
                end
                MEM_RD, MEM_WR: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == '1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array strobes and core response, decoded from state and the same-cycle array/memory inputs.
    always_comb begin
        core_rdata = '0;
        core_stall = 1'b0;
        flush_busy = 1'b0;
        cs_valid   = 1'b0;
        web_valid  = 1'b0;
        oe_valid   = 1'b0;
        addr_index = '0;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        data_we    = 1'b0;
        data_wdata = '0;
        case (state)
            IDLE: core_stall = core_req;
            LOOKUP: begin
                oe_valid   = 1'b1;
                addr_index = req_index;
                if (!lat_we && hit)
                    core_rdata = data_rdata;
                else
                    core_stall = 1'b1;
                if (lat_we && hit) begin
                    data_we    = 1'b1;
                    data_wdata = lat_wdata;
                end
            end
            MEM_RD: begin
                addr_index = req_index;
                core_stall = !mem_ack;
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_wdata = mem_rdata;
                    tag_we     = 1'b1;
                    tag_wdata  = req_tag;
                    cs_valid   = 1'b1;
                    web_valid  = 1'b1;
                    core_rdata = mem_rdata;
                end
            end
            MEM_WR: begin
                addr_index = req_index;
                core_stall = !mem_ack;
            end
            FLUSH: begin
                flush_busy = 1'b1;
                addr_index = flush_cnt;
                cs_valid   = 1'b1;
                core_stall = core_req;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_EN
    logic lookup_hit;
    logic lookup_miss;

    assign lookup_hit  = (state == LOOKUP) && hit;
    assign lookup_miss = (state == LOOKUP) && !hit;

    dcache_perf_cnt u_perf (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_start),
        .hit_inc  (lookup_hit),
        .miss_inc (lookup_miss),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: bench-side cache arrays and memory responder, directed vectors.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        flush, flush_busy;
    logic        valid_data, cs_valid, web_valid, oe_valid;
    logic [5:0]  addr_index;
    logic [23:0] tag_rdata, tag_wdata;
    logic        tag_we;
    logic [31:0] data_rdata, data_wdata;
    logic        data_we;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEXWIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .flush(flush), .flush_busy(flush_busy),
        .valid_data(valid_data), .cs_valid(cs_valid), .web_valid(web_valid), .oe_valid(oe_valid),
        .addr_index(addr_index),
        .tag_rdata(tag_rdata), .tag_we(tag_we), .tag_wdata(tag_wdata),
        .data_rdata(data_rdata), .data_we(data_we), .data_wdata(data_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_PERF_EN
       ,.hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Cache arrays living outside the controller; contents preset invalid.
    logic        valid_arr [64] = '{default: 1'b0};
    logic [23:0] tag_arr   [64] = '{default: 24'h0};
    logic [31:0] data_arr  [64] = '{default: 32'h0};

    assign valid_data = valid_arr[addr_index];
    assign tag_rdata  = tag_arr[addr_index];
    assign data_rdata = data_arr[addr_index];

    always @(posedge clk) begin
        if (cs_valid) valid_arr[addr_index] <= web_valid;
        if (tag_we)   tag_arr[addr_index]   <= tag_wdata;
        if (data_we)  data_arr[addr_index]  <= data_wdata;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          abort;
    } mem_txn_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          lat;
    } core_exp_t;

    mem_txn_t  memq [$];
    core_exp_t sbq  [$];

    int checks   = 0;
    int failures = 0;
    int txn_cnt  = 0;
    int n_cs = 0, n_wclr = 0, n_tagwe = 0, n_datawe = 0, n_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: pops the expected transaction, checks it, acks after the programmed delay.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && !rst) begin
                txn_cnt++;
                if (memq.size() == 0) begin
                    chk("mem_unexpected_req", 1, 0);
                    for (int i = 0; i < 100 && mem_req; i++) begin
                        @(posedge clk); #1;
                    end
                end else begin
                    mem_txn_t t;
                    bit       stable;
                    t = memq.pop_front();
                    stable = 1'b1;
                    chk("mem_we", mem_we, t.we);
                    chk("mem_addr", mem_addr, t.addr);
                    if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
                    for (int i = 0; i < t.delay; i++) begin
                        @(posedge clk); #1;
                        if (!t.abort && (mem_req !== 1'b1 || mem_addr !== t.addr || mem_we !== t.we))
                            stable = 1'b0;
                    end
                    if (!t.abort) chk("mem_stable", stable, 1);
                    mem_rdata = t.rdata;
                    mem_ack   = 1'b1;
                    @(posedge clk); #1;
                    mem_ack   = 1'b0;
                    mem_rdata = '0;
                end
            end
        end
    end

    // Monitor: strobe statistics and scoreboard comparison on every core completion.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            n_cs     += int'(cs_valid);
            n_wclr   += int'(cs_valid && !web_valid);
            n_tagwe  += int'(tag_we);
            n_datawe += int'(data_we);
            n_busy   += int'(flush_busy);
            if (rst) begin
                cyc = 0;
            end else if (core_req) begin
                cyc++;
                if (!core_stall) begin
                    if (sbq.size() == 0) begin
                        chk("core_unexpected_done", 1, 0);
                    end else begin
                        core_exp_t e;
                        e = sbq.pop_front();
                        if (!e.we) chk("core_rdata", core_rdata, e.rdata);
                        if (e.lat != 0) chk("core_latency", cyc, e.lat);
                    end
                    cyc = 0;
                end
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int delay, input bit abort);
        mem_txn_t t;
        t.we = we; t.addr = addr; t.wdata = wd; t.rdata = rd; t.delay = delay; t.abort = abort;
        memq.push_back(t);
    endtask

    // Issue one core request and hold it until completion (bounded).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input int exp_lat);
        core_exp_t e;
        bit        done;
        e.we = we; e.rdata = exp_rdata; e.lat = exp_lat;
        sbq.push_back(e);
        @(posedge clk); #1;
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            if (!core_stall) done = 1'b1;
        end
        chk("req_done", done, 1);
        @(posedge clk); #1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cs, s_wclr, s_tagwe, s_datawe, s_busy, s_txn, ones;
        bit seen;
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_core_stall", core_stall, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_strobes", {cs_valid, tag_we, data_we, oe_valid}, 0);

        // 1: cold load miss and refill
        push_mem(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        chk("t1_valid0", valid_arr[0], 1);
        chk("t1_tag0", tag_arr[0], 24'h1);

        // 2: load hit, two cycles, no memory traffic
        s_txn = txn_cnt;
        issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("t2_no_mem", txn_cnt - s_txn, 0);

        // 3: store hit updates line and writes through
        s_datawe = n_datawe;
        push_mem(1'b1, 32'h100, 32'h12345678, 32'h0, 1, 1'b0);
        issue(1'b1, 32'h100, 32'h12345678, 32'h0, 4);
        chk("t3_data_we", n_datawe - s_datawe, 1);
        chk("t3_data0", data_arr[0], 32'h12345678);
        issue(1'b0, 32'h100, 32'h0, 32'h12345678, 2);

        // 4: store miss touches memory only, then load misses
        s_cs = n_cs; s_tagwe = n_tagwe; s_datawe = n_datawe;
        push_mem(1'b1, 32'h2000, 32'hA5A5_0F0F, 32'h0, 0, 1'b0);
        issue(1'b1, 32'h2000, 32'hA5A5_0F0F, 32'h0, 3);
        chk("t4_no_array_wr", (n_cs - s_cs) + (n_tagwe - s_tagwe) + (n_datawe - s_datawe), 0);
        chk("t4_tag0_kept", tag_arr[0], 24'h1);
        push_mem(1'b0, 32'h2000, 32'h0, 32'hCAFEF00D, 0, 1'b0);
        issue(1'b0, 32'h2000, 32'h0, 32'hCAFEF00D, 3);
        chk("t4_tag0_new", tag_arr[0], 24'h20);

        // 5: flush raised during a slow refill waits, then clears all 64 lines
        s_wclr = n_wclr; s_busy = n_busy;
        push_mem(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 5, 1'b0);
        fork
            issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 8);
            begin
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(posedge clk); #1;
                    if (mem_req) seen = 1'b1;
                end
                chk("t5_mem_req_seen", seen, 1);
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
        join
        repeat (80) @(negedge clk);
        chk("t5_flush_clears", n_wclr - s_wclr, 64);
        chk("t5_flush_busy", n_busy - s_busy, 64);
        ones = 0;
        for (int i = 0; i < 64; i++) ones += int'(valid_arr[i]);
        chk("t5_all_invalid", ones, 0);
        push_mem(1'b0, 32'h100, 32'h0, 32'h0BADF00D, 0, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 32'h0BADF00D, 3);

        // 6: reset while a refill is outstanding; the late ack must be ignored
        push_mem(1'b0, 32'h3000, 32'h0, 32'hFFFF0000, 6, 1'b1);
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h3000;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_req) seen = 1'b1;
        end
        chk("t6_mem_req_seen", seen, 1);
        @(posedge clk); #1;
        s_cs = n_cs; s_tagwe = n_tagwe; s_datawe = n_datawe;
        rst = 1'b1; core_req = 1'b0; core_addr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_mem_req_drop", mem_req, 0);
        chk("t6_core_stall", core_stall, 0);
        repeat (12) @(negedge clk);
        chk("t6_no_array_wr", (n_cs - s_cs) + (n_tagwe - s_tagwe) + (n_datawe - s_datawe), 0);
        chk("t6_data0_kept", data_arr[0], 32'h0BADF00D);
        chk("t6_tag0_kept", tag_arr[0], 24'h1);

        chk("sb_empty", sbq.size(), 0);
        chk("memq_empty", memq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
